// File: rtl/pieo_datatypes.sv
// pieo_datatypes: shared sizing constants and the sublist element type for the PIEO blocks
package pieo_datatypes;
    localparam int ID_LOG    = 3;
    localparam int RANK_LOG  = 4;
    localparam int TIME_LOG  = 8;
    localparam int LIST_SIZE = 2 ** ID_LOG;
    typedef struct packed {
        logic [ID_LOG-1:0]   id;
        logic [RANK_LOG-1:0] rank;
        logic [TIME_LOG-1:0] send_time;
    } SublistElement;
endpackage

// File: rtl/pieo_ingress_if.sv
// pieo_ingress_if: enqueue/dequeue request handshakes and the command bus toward the PIEO core
interface pieo_ingress_if;
    import pieo_datatypes::*;
    logic                in_enq_valid, in_enq_ready;
    logic [ID_LOG-1:0]   in_enq_id;
    logic [RANK_LOG-1:0] in_enq_rank;
    logic [TIME_LOG-1:0] in_enq_send_time;
    logic                in_deq_valid, in_deq_ready;
    logic [TIME_LOG-1:0] in_deq_time;
    logic                core_valid, core_ready, core_op, core_deq_hit;
    SublistElement       core_elem;
    logic [TIME_LOG-1:0] core_deq_time;
    modport slave (
        input  in_enq_valid, in_enq_id, in_enq_rank, in_enq_send_time, in_deq_valid, in_deq_time,
               core_ready, core_deq_hit,
        output in_enq_ready, in_deq_ready, core_valid, core_op, core_elem, core_deq_time
    );
    modport master (
        output in_enq_valid, in_enq_id, in_enq_rank, in_enq_send_time, in_deq_valid, in_deq_time,
               core_ready, core_deq_hit,
        input  in_enq_ready, in_deq_ready, core_valid, core_op, core_elem, core_deq_time
    );
endinterface

// File: rtl/pieo_ingress.sv
// pieo_ingress: buffers enqueue/dequeue requests and issues them to the PIEO core; PIEO_INGRESS_STATS_EN adds drop_count
module pieo_ingress
    import pieo_datatypes::*;
#(
    parameter int ENQ_FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    pieo_ingress_if.slave     bus,
    output logic [ID_LOG:0]   occupancy,
    output logic              full,
    output logic              empty,
    output logic              deq_miss
`ifdef PIEO_INGRESS_STATS_EN
    ,
    output logic [15:0]       drop_count
`endif
);
    localparam int PW = $clog2(ENQ_FIFO_DEPTH);
    localparam logic [ID_LOG:0]   OCC_MAX = (ID_LOG+1)'(LIST_SIZE);
    localparam logic [ID_LOG+1:0] ADM_MAX = (ID_LOG+2)'(LIST_SIZE);
    SublistElement       mem [ENQ_FIFO_DEPTH];
    logic [PW:0]         wr_ptr, rd_ptr;
    logic [TIME_LOG-1:0] deq_time_q;
    logic [ID_LOG+1:0]   adm;
    logic                deq_held, last_op, fifo_full, fifo_empty, adm_full, drop, miss;
    logic                enq_cand, deq_cand, load, pick_deq, push, pop, inc, dec;
    assign fifo_empty = wr_ptr == rd_ptr;
    assign fifo_full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    // an enqueue sitting in the output register is already committed against capacity
    assign adm        = {1'b0, occupancy} + {{(ID_LOG+1){1'b0}}, bus.core_valid && !bus.core_op};
    assign adm_full   = adm >= ADM_MAX;
    assign drop       = !fifo_empty && adm_full;
    assign enq_cand   = !fifo_empty && !adm_full;
    assign miss       = deq_held && occupancy == '0 && !(bus.core_valid && !bus.core_op);
    assign deq_cand   = deq_held && !miss;
    assign load       = (!bus.core_valid || bus.core_ready) && (enq_cand || deq_cand);
    assign pick_deq   = deq_cand && (!enq_cand || !last_op);
    assign push       = bus.in_enq_valid && bus.in_enq_ready;
    assign pop        = drop || (load && !pick_deq);
    assign inc        = bus.core_valid && bus.core_ready && !bus.core_op;
    assign dec        = bus.core_deq_hit && occupancy != '0;
    assign bus.in_enq_ready = !fifo_full && !rst;
    assign bus.in_deq_ready = !deq_held && !rst;
    assign full  = occupancy == OCC_MAX;
    assign empty = occupancy == '0;
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[PW-1:0]] <= {bus.in_enq_id, bus.in_enq_rank, bus.in_enq_send_time};
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr            <= '0;
            rd_ptr            <= '0;
            deq_held          <= 1'b0;
            deq_time_q        <= '0;
            last_op           <= 1'b0;
            deq_miss          <= 1'b0;
            occupancy         <= '0;
            bus.core_valid    <= 1'b0;
            bus.core_op       <= 1'b0;
            bus.core_elem     <= '0;
            bus.core_deq_time <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (bus.in_deq_valid && bus.in_deq_ready) begin
                deq_held   <= 1'b1;
                deq_time_q <= bus.in_deq_time;
            end else if (miss || (load && pick_deq)) deq_held <= 1'b0;
            deq_miss <= miss;
            if (load) begin
                bus.core_valid    <= 1'b1;
                bus.core_op       <= pick_deq;
                bus.core_elem     <= pick_deq ? SublistElement'(0) : mem[rd_ptr[PW-1:0]];
                bus.core_deq_time <= pick_deq ? deq_time_q : '0;
                last_op           <= pick_deq;
            end else if (bus.core_ready) bus.core_valid <= 1'b0;
            if (inc && !dec && occupancy != OCC_MAX) occupancy <= occupancy + 1'b1;
            else if (dec && !inc) occupancy <= occupancy - 1'b1;
        end
    end
`ifdef PIEO_INGRESS_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) drop_count <= '0;
        else if (drop && drop_count != 16'hFFFF) drop_count <= drop_count + 1'b1;
    end
`endif
endmodule

// File: tb/tb_pieo_ingress.sv
// tb_pieo_ingress: directed self-checking bench for pieo_ingress
module tb_pieo_ingress;
    import pieo_datatypes::*;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [ID_LOG:0] occupancy;
    logic full, empty, deq_miss;
`ifdef PIEO_INGRESS_STATS_EN
    logic [15:0] drop_count;
`endif
    int n_checks = 0;
    int n_fail = 0;
    pieo_ingress_if bus();
    pieo_ingress #(.ENQ_FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .bus(bus.slave), .occupancy(occupancy),
        .full(full), .empty(empty), .deq_miss(deq_miss)
`ifdef PIEO_INGRESS_STATS_EN
        , .drop_count(drop_count)
`endif
    );
    always #5 clk = ~clk;
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask
    task automatic enq(input int id, input int rank);
        bus.in_enq_valid     = 1'b1;
        bus.in_enq_id        = ID_LOG'(id);
        bus.in_enq_rank      = RANK_LOG'(rank);
        bus.in_enq_send_time = '0;
        tick();
        bus.in_enq_valid = 1'b0;
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
    initial begin
        bus.in_enq_valid = 0; bus.in_enq_id = '0; bus.in_enq_rank = '0; bus.in_enq_send_time = '0;
        bus.in_deq_valid = 0; bus.in_deq_time = '0; bus.core_ready = 0; bus.core_deq_hit = 0;
        tick();
        tick();
        check("rst_enq_ready", bus.in_enq_ready, 0);
        check("rst_deq_ready", bus.in_deq_ready, 0);
        check("rst_core_valid", bus.core_valid, 0);
        check("rst_occupancy", occupancy, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_deq_miss", deq_miss, 0);
        check("rst_core_op", bus.core_op, 0);
        check("rst_core_elem", bus.core_elem, 0);
        check("rst_core_deq_time", bus.core_deq_time, 0);
        rst = 1'b0;
        tick();
        check("post_rst_enq_ready", bus.in_enq_ready, 1);
        check("post_rst_deq_ready", bus.in_deq_ready, 1);
        // single enqueue latency and occupancy update
        bus.core_ready = 1'b1;
        enq(3, 5);
        check("lat_valid_k", bus.core_valid, 0);
        tick();
        check("lat_valid_k1", bus.core_valid, 1);
        check("lat_op", bus.core_op, 0);
        check("lat_id", bus.core_elem.id, 3);
        check("lat_rank", bus.core_elem.rank, 5);
        check("lat_occ_before", occupancy, 0);
        tick();
        check("lat_occ_after", occupancy, 1);
        check("lat_empty", empty, 0);
        bus.core_deq_hit = 1'b1;
        tick();
        check("hit_dec", occupancy, 0);
        tick();
        bus.core_deq_hit = 1'b0;
        check("hit_at_zero", occupancy, 0);
        // dequeue miss on an empty core
        bus.in_deq_valid = 1'b1;
        bus.in_deq_time  = 8'd7;
        tick();
        bus.in_deq_valid = 1'b0;
        check("miss_deq_ready_low", bus.in_deq_ready, 0);
        check("miss_pulse_early", deq_miss, 0);
        tick();
        check("miss_pulse", deq_miss, 1);
        check("miss_no_issue", bus.core_valid, 0);
        check("miss_deq_ready_back", bus.in_deq_ready, 1);
        tick();
        check("miss_pulse_end", deq_miss, 0);
        // fill to capacity then overflow
        for (int i = 0; i < LIST_SIZE; i++) begin
            enq(i, i);
            tick();
            tick();
        end
        check("fill_occ", occupancy, LIST_SIZE);
        check("fill_full", full, 1);
        enq(7, 7);
        tick();
        check("drop_no_issue", bus.core_valid, 0);
        check("drop_occ", occupancy, LIST_SIZE);
        check("drop_enq_ready", bus.in_enq_ready, 1);
`ifdef PIEO_INGRESS_STATS_EN
        check("drop_count", drop_count, 1);
`endif
        tick();
        check("drop_still_idle", bus.core_valid, 0);
        bus.core_deq_hit = 1'b1;
        repeat (5) tick();
        bus.core_deq_hit = 1'b0;
        check("drain_occ", occupancy, 3);
        // contention: enqueue and dequeue offered together every cycle
        bus.in_enq_id = 3'd2; bus.in_enq_rank = 4'd1;
        bus.in_enq_valid = 1'b1;
        bus.in_deq_valid = 1'b1;
        bus.in_deq_time  = 8'd9;
        tick();
        check("alt_idle", bus.core_valid, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("alt_valid", bus.core_valid, 1);
            check("alt_op", bus.core_op, (i % 2 == 0) ? 1 : 0);
            if (i == 0) check("alt_deq_time", bus.core_deq_time, 9);
        end
        bus.in_enq_valid = 1'b0;
        bus.in_deq_valid = 1'b0;
        repeat (12) tick();
        check("alt_occ", occupancy, 8);
        check("alt_idle_end", bus.core_valid, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        // back-pressure from the core
        bus.core_ready = 1'b0;
        for (int i = 0; i < 5; i++) enq(i + 1, 2);
        check("bp_enq_ready", bus.in_enq_ready, 0);
        check("bp_valid", bus.core_valid, 1);
        check("bp_id", bus.core_elem.id, 1);
        repeat (5) tick();
        check("bp_id_stable", bus.core_elem.id, 1);
        check("bp_rank_stable", bus.core_elem.rank, 2);
        check("bp_op_stable", bus.core_op, 0);
        check("bp_valid_stable", bus.core_valid, 1);
        check("bp_enq_ready_stable", bus.in_enq_ready, 0);
        // reset with buffered enqueues
        rst = 1'b1;
        tick();
        check("mid_rst_valid", bus.core_valid, 0);
        check("mid_rst_enq_ready", bus.in_enq_ready, 0);
        rst = 1'b0;
        tick();
        check("after_rst_enq_ready", bus.in_enq_ready, 1);
        check("after_rst_deq_ready", bus.in_deq_ready, 1);
        check("after_rst_valid", bus.core_valid, 0);
        check("after_rst_occ", occupancy, 0);
        bus.core_ready = 1'b1;
        repeat (3) tick();
        check("after_rst_no_replay", bus.core_valid, 0);
        check("after_rst_occ_hold", occupancy, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
